// File: rtl/n64_bus_sequencer.sv
// N64 controller bus sequencer: tracks receive, turnaround, reply and error recovery on one line.
// Optional poll counter enabled by defining N64_SEQ_STATS_EN.
module n64_bus_sequencer #(
  parameter int unsigned TURN_CYCLES = 8,
  parameter int unsigned RX_TIMEOUT  = 1024,
  parameter int unsigned TX_TIMEOUT  = 2048,
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        data_rx,
  input  logic        rx_done,
  input  logic [7:0]  cmd,
  input  logic        tx_done,
  input  logic [15:0] button_in,
  input  logic [15:0] stick_in,
  output logic [15:0] button_state,
  output logic [15:0] stick_state,
  output logic        tx_start,
  output logic        cur_operation,
  output logic        rx_abort,
  output logic        bus_error,
  output logic [15:0] poll_count
);

  localparam int unsigned MAX_AB = (RX_TIMEOUT > TX_TIMEOUT) ? RX_TIMEOUT : TX_TIMEOUT;
  localparam int unsigned MAX_CD = (TURN_CYCLES > IDLE_CYCLES) ? TURN_CYCLES : IDLE_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] RX_LAST   = CW'(RX_TIMEOUT - 1);
  localparam logic [CW-1:0] TX_LAST   = CW'(TX_TIMEOUT - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECEIVE, S_TURNAROUND, S_TRANSMIT, S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]   button_q, button_d, stick_q, stick_d;
  logic          cmd_ok, snap_en;

  // One counter serves as the timeout timer and as the consecutive-high counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign cmd_ok  = (cmd == 8'h00) || (cmd == 8'h01) || (cmd == 8'hFF);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    rx_abort  = 1'b0;
    bus_error = 1'b0;
    snap_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!data_rx) state_d = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (rx_done) begin
          cnt_d   = '0;
          snap_en = (cmd == 8'h01);
          state_d = cmd_ok ? S_TURNAROUND : S_IDLE;
        end else if (cnt_q == RX_LAST) begin
          cnt_d     = '0;
          state_d   = S_RECOVER;
          rx_abort  = 1'b1;
          bus_error = 1'b1;
        end
      end
      S_TURNAROUND: begin
        if (!data_rx) cnt_d = '0;
        else if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_TRANSMIT;
        end
      end
      S_TRANSMIT: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == TX_LAST) begin
          cnt_d     = '0;
          state_d   = S_RECOVER;
          bus_error = 1'b1;
        end
      end
      S_RECOVER: begin
        if (!data_rx) cnt_d = '0;
        else if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    button_d = snap_en ? button_in : button_q;
    stick_d  = snap_en ? stick_in  : stick_q;
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      button_q <= '0;
      stick_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      button_q <= button_d;
      stick_q  <= stick_d;
    end
  end

  // Decoded straight from the state flop so an async reset drops the driver at once.
  assign cur_operation = (state_q == S_TRANSMIT);
  assign tx_start      = (state_q == S_TRANSMIT) && (cnt_q == '0);
  assign button_state  = button_q;
  assign stick_state   = stick_q;

`ifdef N64_SEQ_STATS_EN
  logic [15:0] poll_count_q, poll_count_d;

  always_comb poll_count_d = snap_en ? poll_count_q + 16'd1 : poll_count_q;

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) poll_count_q <= '0;
    else       poll_count_q <= poll_count_d;
  end

  assign poll_count = poll_count_q;
`else
  assign poll_count = '0;
`endif

endmodule

// File: tb/tb_n64_bus_sequencer.sv
// Directed bench for n64_bus_sequencer: mode/age model checked every cycle plus literal latency checks.
module tb_n64_bus_sequencer;

  localparam int TURN_CYCLES = 8;
  localparam int RX_TIMEOUT  = 1024;
  localparam int TX_TIMEOUT  = 2048;
  localparam int IDLE_CYCLES = 64;

  logic        sample_clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_rx = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        tx_done = 1'b0;
  logic [15:0] button_in = 16'h0;
  logic [15:0] stick_in = 16'h0;
  logic [15:0] button_state, stick_state, poll_count;
  logic        tx_start, cur_operation, rx_abort, bus_error;

  n64_bus_sequencer #(
    .TURN_CYCLES(TURN_CYCLES), .RX_TIMEOUT(RX_TIMEOUT),
    .TX_TIMEOUT(TX_TIMEOUT), .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .sample_clk(sample_clk), .reset(reset), .data_rx(data_rx),
    .rx_done(rx_done), .cmd(cmd), .tx_done(tx_done),
    .button_in(button_in), .stick_in(stick_in),
    .button_state(button_state), .stick_state(stick_state),
    .tx_start(tx_start), .cur_operation(cur_operation),
    .rx_abort(rx_abort), .bus_error(bus_error), .poll_count(poll_count)
  );

  always #5 sample_clk = ~sample_clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the bus is in, how long it has been there, and the current high run.
  typedef enum {M_IDLE, M_RX, M_TA, M_TX, M_REC} md_t;
  md_t         m_mode = M_IDLE, m_next;
  int          m_age = 0, m_run = 0, m_run_n;
  logic        m_snap;
  logic [15:0] m_btn = 0, m_stk = 0;
  int          m_polls = 0;

  always @* begin
    m_run_n = data_rx ? m_run + 1 : 0;
    m_next  = m_mode;
    m_snap  = 1'b0;
    case (m_mode)
      M_IDLE: if (!data_rx) m_next = M_RX;
      M_RX: begin
        if (rx_done) begin
          m_next = (cmd == 8'h00 || cmd == 8'h01 || cmd == 8'hFF) ? M_TA : M_IDLE;
          m_snap = (cmd == 8'h01);
        end else if (m_age + 1 == RX_TIMEOUT) m_next = M_REC;
      end
      M_TA:  if (m_run_n == TURN_CYCLES) m_next = M_TX;
      M_TX: begin
        if (tx_done) m_next = M_IDLE;
        else if (m_age + 1 == TX_TIMEOUT) m_next = M_REC;
      end
      M_REC: if (m_run_n == IDLE_CYCLES) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  always @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      m_mode <= M_IDLE; m_age <= 0; m_run <= 0;
      m_btn <= 0; m_stk <= 0; m_polls <= 0;
    end else begin
      m_mode <= m_next;
      if (m_next != m_mode) begin
        m_age <= 0; m_run <= 0;
      end else begin
        m_age <= m_age + 1; m_run <= m_run_n;
      end
      if (m_snap) begin
        m_btn <= button_in; m_stk <= stick_in; m_polls <= m_polls + 1;
      end
    end
  end

  logic chk_en = 1'b0;
  int   cyc = 0;
  int   n_txs = 0, n_berr = 0, n_abort = 0, berr_cyc = 0, abort_cyc = 0;

  always @(posedge sample_clk) cyc <= cyc + 1;

  always @(negedge sample_clk) begin
    if (tx_start)  n_txs <= n_txs + 1;
    if (bus_error) begin n_berr <= n_berr + 1; berr_cyc <= cyc; end
    if (rx_abort)  begin n_abort <= n_abort + 1; abort_cyc <= cyc; end
  end

  always @(negedge sample_clk) begin
    if (chk_en) begin
      logic e_abort, e_berr;
      e_abort = (m_mode == M_RX) && !rx_done && (m_age + 1 == RX_TIMEOUT);
      e_berr  = e_abort || ((m_mode == M_TX) && !tx_done && (m_age + 1 == TX_TIMEOUT));
      chk("cur_operation", cur_operation, m_mode == M_TX);
      chk("tx_start", tx_start, (m_mode == M_TX) && (m_age == 0));
      chk("rx_abort", rx_abort, e_abort);
      chk("bus_error", bus_error, e_berr);
      chk("button_state", button_state, m_btn);
      chk("stick_state", stick_state, m_stk);
`ifdef N64_SEQ_STATS_EN
      chk("poll_count", poll_count, m_polls[15:0]);
`else
      chk("poll_count", poll_count, 16'h0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sample_clk);
    #1;
  endtask

  int rxd_cyc;

  // Frame start, a few bit times, then the rx_done pulse; live pad inputs change afterwards.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] b, input logic [15:0] s);
    data_rx = 1'b0; tick(1);
    data_rx = 1'b1; tick(3);
    rx_done = 1'b1; cmd = c; button_in = b; stick_in = s;
    rxd_cyc = cyc;
    tick(1);
    rx_done = 1'b0; cmd = 8'hA5; button_in = ~b; stick_in = ~s;
  endtask

  task automatic wait_txs();
    for (int k = 0; k < 40 && !tx_start; k++) tick(1);
    chk("wait_tx_start", tx_start, 1'b1);
  endtask

  task automatic finish_tx();
    tick(2); tx_done = 1'b1; tick(1); tx_done = 1'b0; tick(1);
  endtask

  initial begin
    int t0, b0, e0;
    tick(1);
    chk_en = 1'b1;
    chk("reset_cur_op", cur_operation, 1'b0);
    chk("reset_button", button_state, 16'h0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Poll with snapshot
    send_cmd(8'h01, 16'h1234, 16'h80F0);
    wait_txs();
    chk("poll_latency", cyc - rxd_cyc, 9);
    chk("poll_cur_op", cur_operation, 1'b1);
    chk("poll_button", button_state, 16'h1234);
    chk("poll_stick", stick_state, 16'h80F0);
    finish_tx();
    chk("poll_done_cur_op", cur_operation, 1'b0);

    // Unsupported command
    t0 = n_txs;
    send_cmd(8'h02, 16'h5555, 16'hAAAA);
    tick(20);
    chk("unsup_no_tx", n_txs, t0);
    chk("unsup_button_held", button_state, 16'h1234);

    // Turnaround glitch at count 5
    send_cmd(8'h00, 16'h0, 16'h0);
    tick(5);
    data_rx = 1'b0; tick(1);
    data_rx = 1'b1;
    wait_txs();
    chk("glitch_latency", cyc - rxd_cyc, 15);
    finish_tx();

    // RX timeout then recovery
    e0 = n_berr; b0 = n_abort;
    data_rx = 1'b0; t0 = cyc; tick(1);
    data_rx = 1'b1; tick(RX_TIMEOUT + 5);
    chk("rxto_berr_count", n_berr - e0, 1);
    chk("rxto_abort_count", n_abort - b0, 1);
    chk("rxto_berr_cycle", berr_cyc - t0, 1024);
    chk("rxto_abort_cycle", abort_cyc - t0, 1024);
    tick(IDLE_CYCLES + 4);
    send_cmd(8'h01, 16'hBEEF, 16'h0102);
    wait_txs();
    chk("rxto_poll_latency", cyc - rxd_cyc, 9);
    finish_tx();

    // TX timeout
    send_cmd(8'hFF, 16'h0, 16'h0);
    wait_txs();
    t0 = cyc; e0 = n_berr;
    tick(TX_TIMEOUT + 3);
    chk("txto_berr_count", n_berr - e0, 1);
    chk("txto_berr_cycle", berr_cyc - t0, 2047);
    chk("txto_cur_op", cur_operation, 1'b0);
    tick(IDLE_CYCLES + 4);

    // tx_done coincident with timeout expiry
    send_cmd(8'h00, 16'h0, 16'h0);
    wait_txs();
    e0 = n_berr;
    tick(TX_TIMEOUT - 1);
    tx_done = 1'b1; tick(1); tx_done = 1'b0; tick(2);
    chk("coinc_no_berr", n_berr, e0);
    chk("coinc_cur_op", cur_operation, 1'b0);
    send_cmd(8'h00, 16'h0, 16'h0);
    wait_txs();
    chk("coinc_next_latency", cyc - rxd_cyc, 9);

    // Async reset mid-transmit
    tick(3);
    #2 reset = 1'b1;
    #1 chk("async_reset_cur_op", cur_operation, 1'b0);
    chk("async_reset_button", button_state, 16'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Three polls for stats
    for (int i = 0; i < 3; i++) begin
      send_cmd(8'h01, 16'h1000 + 16'(i), 16'h2000);
      wait_txs();
      finish_tx();
    end
`ifdef N64_SEQ_STATS_EN
    chk("stats_poll_count", poll_count, 16'd3);
`else
    chk("stats_poll_count", poll_count, 16'd0);
`endif
    chk("stats_button", button_state, 16'h1002);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/n64_bus_sequencer.md
N64_BUS_SEQUENCER -- requirements
Module: n64_bus_sequencer

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 8: consecutive idle-high samples required before a reply starts.
REQ-002 SHALL have parameter RX_TIMEOUT, default 1024: sample_clk cycles allowed from line activity to rx_done.
REQ-003 SHALL have parameter TX_TIMEOUT, default 2048: cycles allowed from tx_start to tx_done.
REQ-004 SHALL have parameter IDLE_CYCLES, default 64: consecutive high samples required to leave error recovery.
REQ-005 SHALL have port sample_clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port data_rx, input, 1: sampled bus line, idle high.
REQ-008 SHALL have port rx_done, input, 1: one-cycle pulse when the receiver has completed a command frame.
REQ-009 SHALL have port cmd, input, 8: received command byte, valid while rx_done=1.
REQ-010 SHALL have port tx_done, input, 1: one-cycle pulse when the transmitter has finished its reply.
REQ-011 SHALL have ports button_in and stick_in, input, 16 each: live pad state.
REQ-012 SHALL have ports button_state and stick_state, output, 16 each: snapshot presented to the transmitter.
REQ-013 SHALL have port tx_start, output, 1: one-cycle reply-start pulse.
REQ-014 SHALL have port cur_operation, output, 1: 0 = RX (line released), 1 = TX (device drives).
REQ-015 SHALL have port rx_abort, output, 1: one-cycle pulse that clears the receiver after a timeout.
REQ-016 SHALL have port bus_error, output, 1: one-cycle pulse on any timeout.
REQ-017 SHALL have port poll_count, output, 16: count of accepted 0x01 polls (see Configuration).

Function
REQ-018 SHALL implement states IDLE, RECEIVE, TURNAROUND, TRANSMIT and RECOVER.
REQ-019 SHALL drive cur_operation=1 only in TRANSMIT, and 0 in all other states.
REQ-020 In IDLE: data_rx=0 on any sample -> RECEIVE with the timer cleared.
REQ-021 In RECEIVE: rx_done with cmd in {0x00, 0x01, 0xFF} -> TURNAROUND; rx_done with any other cmd -> IDLE, no reply.
REQ-022 In RECEIVE: timer reaches RX_TIMEOUT-1 without rx_done -> RECOVER, with rx_abort and bus_error pulsed on that transition cycle.
REQ-023 SHALL give rx_done priority over an RX timeout expiring in the same cycle.
REQ-024 On the rx_done edge with cmd=0x01, SHALL register button_in/stick_in into button_state/stick_state; the snapshot SHALL stay unchanged until the next accepted 0x01.
REQ-025 In TURNAROUND: count consecutive data_rx=1 samples; any 0 sample restarts the count at 0; count=TURN_CYCLES -> TRANSMIT.
REQ-026 SHALL assert tx_start for exactly the first cycle spent in TRANSMIT.
REQ-027 In TRANSMIT: data_rx SHALL be ignored; tx_done -> IDLE; timer reaches TX_TIMEOUT-1 -> RECOVER with bus_error pulsed.
REQ-028 SHALL give tx_done priority over a TX timeout expiring in the same cycle.
REQ-029 In RECOVER: IDLE_CYCLES consecutive data_rx=1 samples -> IDLE; any 0 sample restarts the count.
REQ-030 SHALL ignore rx_done outside RECEIVE, and tx_done outside TRANSMIT.
REQ-031 Timers SHALL saturate, not wrap; counter widths SHALL be sized by $clog2 of the largest parameter plus 1.

Reset
REQ-032 Reset SHALL force IDLE, clear all counters, and set cur_operation=0, tx_start=0, rx_abort=0, bus_error=0, button_state=0, stick_state=0 and poll_count=0.
REQ-033 Reset asserted mid-TRANSMIT SHALL drop cur_operation to 0 asynchronously, without waiting for a clock edge.

Configuration
REQ-034 Macro N64_SEQ_STATS_EN SHALL control poll counting.
REQ-035 With N64_SEQ_STATS_EN defined, poll_count SHALL increment by 1 per accepted 0x01 and wrap 0xFFFF -> 0x0000.
REQ-036 Without N64_SEQ_STATS_EN, poll_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-037 Poll: data_rx low, then rx_done with cmd=0x01, button_in=0x1234, stick_in=0x80F0, line high 8 cycles -> tx_start on the 9th cycle after rx_done, cur_operation=1, button_state=0x1234, stick_state=0x80F0; after tx_done -> cur_operation=0, state IDLE.
REQ-038 Unsupported: rx_done with cmd=0x02 -> no tx_start, cur_operation stays 0, returns to IDLE.
REQ-039 Turnaround glitch: data_rx low at turnaround count 5 -> count restarts; tx_start occurs 8 high samples after the glitch.
REQ-040 RX timeout: data_rx low, no rx_done for 1024 cycles -> rx_abort and bus_error pulse together; 64 high samples later -> IDLE; a following poll is answered normally.
REQ-041 TX timeout, and tx_done coincident with timeout: no tx_done -> bus_error at cycle 2048 and cur_operation=0; tx_done on the cycle the timeout expires -> IDLE, no bus_error.
REQ-042 Reset and stats: reset asserted mid-TRANSMIT -> cur_operation=0 before the next edge; 3 polls -> poll_count=3 with N64_SEQ_STATS_EN, 0 without.
